// File: rtl/rsff_pulse_driver.sv
// rsff_pulse_driver: registered, non-overlapping set/reset pulses for a NOR RS latch.
// Optional q feedback check is built with RSFF_PULSE_DRIVER_FBCHK_EN.
module rsff_pulse_driver #(
  parameter int unsigned PW  = 2,
  parameter int unsigned GAP = 1
) (
  input  logic       clk,
  input  logic       n_res,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  input  logic [1:0] cmd_sel,
  output logic       cmd_ready,
  output logic       s,
  output logic       res1,
  output logic       res2,
  output logic       res3,
  output logic       busy,
  output logic       shadow_q,
  input  logic       q_fb,
  output logic       fb_err
);

  typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_t;

  localparam logic [3:0] PW_LAST  = (PW == 0) ? 4'd0 : 4'(PW - 1);
  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       set_q, set_d;
  logic       s_q, s_d;
  logic [2:0] res_q, res_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       shadow_d;

  function automatic logic [2:0] sel_lines(input logic [1:0] sel);
    logic [2:0] r;
    unique case (sel)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b111;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    set_d    = set_q;
    s_d      = s_q;
    res_d    = res_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: begin
        s_d     = 1'b0;
        res_d   = 3'b000;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (cmd_valid && ready_q) begin
          state_d = PULSE;
          cnt_d   = PW_LAST;
          set_d   = cmd_set;
          s_d     = cmd_set;
          res_d   = cmd_set ? 3'b000 : sel_lines(cmd_sel);
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      PULSE: begin
        if (cnt_q == 4'd0) begin
          s_d      = 1'b0;
          res_d    = 3'b000;
          shadow_d = set_q;
          if (GAP != 0) begin
            state_d = GUARD;
            cnt_d   = GAP_LAST;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GUARD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        s_d     = 1'b0;
        res_d   = 3'b000;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_res) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      set_q    <= 1'b0;
      s_q      <= 1'b0;
      res_q    <= 3'b000;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      shadow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      s_q      <= s_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef RSFF_PULSE_DRIVER_FBCHK_EN
  logic chk_q, chk_d;
  logic fb_err_q, fb_err_d;

  // chk_q marks the first cycle after a pulse, when the latch has settled
  always_comb begin
    chk_d    = (state_q == PULSE) && (cnt_q == 4'd0);
    fb_err_d = fb_err_q | (chk_q & (q_fb != shadow_q));
  end

  always_ff @(posedge clk) begin
    if (!n_res) begin
      chk_q    <= 1'b0;
      fb_err_q <= 1'b0;
    end else begin
      chk_q    <= chk_d;
      fb_err_q <= fb_err_d;
    end
  end

  assign fb_err = fb_err_q;
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign fb_err      = 1'b0;
`endif

  assign cmd_ready = ready_q;
  assign s         = s_q;
  assign res1      = res_q[0];
  assign res2      = res_q[1];
  assign res3      = res_q[2];
  assign busy      = busy_q;

endmodule

// File: tb/tb_rsff_pulse_driver.sv
// Directed bench for rsff_pulse_driver: instance a (PW=2,GAP=1), instance b (PW=4,GAP=0).
module tb_rsff_pulse_driver;

  localparam bit FB_EN =
`ifdef RSFF_PULSE_DRIVER_FBCHK_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_n_res, a_valid, a_set;
  logic [1:0] a_sel;
  logic       a_ready, a_s, a_r1, a_r2, a_r3, a_busy, a_shadow, a_err;
  logic       a_lq, a_force0, a_qfb;

  logic       b_n_res, b_valid, b_set;
  logic [1:0] b_sel;
  logic       b_ready, b_s, b_r1, b_r2, b_r3, b_busy, b_shadow, b_err;
  logic       b_lq, b_qfb;

  rsff_pulse_driver #(.PW(2), .GAP(1)) u_a (
    .clk(clk), .n_res(a_n_res), .cmd_valid(a_valid), .cmd_set(a_set),
    .cmd_sel(a_sel), .cmd_ready(a_ready), .s(a_s), .res1(a_r1),
    .res2(a_r2), .res3(a_r3), .busy(a_busy), .shadow_q(a_shadow),
    .q_fb(a_qfb), .fb_err(a_err)
  );

  rsff_pulse_driver #(.PW(4), .GAP(0)) u_b (
    .clk(clk), .n_res(b_n_res), .cmd_valid(b_valid), .cmd_set(b_set),
    .cmd_sel(b_sel), .cmd_ready(b_ready), .s(b_s), .res1(b_r1),
    .res2(b_r2), .res3(b_r3), .busy(b_busy), .shadow_q(b_shadow),
    .q_fb(b_qfb), .fb_err(b_err)
  );

  // behavioural NOR latches driven by the pulse lines
  always @* begin
    if (a_s) a_lq = 1'b1;
    else if (a_r1 | a_r2 | a_r3) a_lq = 1'b0;
  end
  always @* begin
    if (b_s) b_lq = 1'b1;
    else if (b_r1 | b_r2 | b_r3) b_lq = 1'b0;
  end
  assign a_qfb = a_force0 ? 1'b0 : a_lq;
  assign b_qfb = b_lq;

  task automatic test_reset;
    a_n_res = 0; b_n_res = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_s, a_r3, a_r2, a_r1, a_busy, a_ready} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_a_hold got %b want 000000",
               {a_s, a_r3, a_r2, a_r1, a_busy, a_ready});
    end
    checks++;
    if ({b_s, b_r3, b_r2, b_r1, b_busy, b_ready} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_b_hold got %b want 000000",
               {b_s, b_r3, b_r2, b_r1, b_busy, b_ready});
    end
    a_n_res = 1; b_n_res = 1;
    @(negedge clk);
    checks++;
    if ({a_s, a_r3, a_r2, a_r1, a_busy, a_ready, a_shadow, a_err}
        !== 8'b00000100) begin
      errors++;
      $display("FAIL rst_a_rel got %b want 00000100",
               {a_s, a_r3, a_r2, a_r1, a_busy, a_ready, a_shadow, a_err});
    end
    checks++;
    if ({b_s, b_r3, b_r2, b_r1, b_busy, b_ready, b_shadow, b_err}
        !== 8'b00000100) begin
      errors++;
      $display("FAIL rst_b_rel got %b want 00000100",
               {b_s, b_r3, b_r2, b_r1, b_busy, b_ready, b_shadow, b_err});
    end
  endtask

  task automatic test_set;
    a_set = 1; a_sel = 2'd0; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({a_s, a_r3, a_r2, a_r1, a_busy, a_ready} !== 6'b100010) begin
        errors++;
        $display("FAIL set_pulse%0d got %b want 100010", k,
                 {a_s, a_r3, a_r2, a_r1, a_busy, a_ready});
      end
      @(negedge clk);
    end
    checks++;
    if ({a_s, a_r3, a_r2, a_r1, a_busy, a_ready, a_shadow} !== 7'b0000101) begin
      errors++;
      $display("FAIL set_guard got %b want 0000101",
               {a_s, a_r3, a_r2, a_r1, a_busy, a_ready, a_shadow});
    end
    @(negedge clk);
    checks++;
    if ({a_busy, a_ready, a_shadow, a_err} !== 4'b0110) begin
      errors++;
      $display("FAIL set_idle got %b want 0110",
               {a_busy, a_ready, a_shadow, a_err});
    end
  endtask

  task automatic test_reset_lines(input logic [1:0] sel,
                                  input logic [2:0] exp_r);
    a_set = 0; a_sel = sel; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if ({a_s, a_r3, a_r2, a_r1} !== {1'b0, exp_r}) begin
        errors++;
        $display("FAIL rst_lines sel%0d cyc%0d got %b want %b", sel, k,
                 {a_s, a_r3, a_r2, a_r1}, {1'b0, exp_r});
      end
      @(negedge clk);
    end
    checks++;
    if ({a_s, a_r3, a_r2, a_r1, a_shadow} !== 5'b00000) begin
      errors++;
      $display("FAIL rst_lines_end sel%0d got %b want 00000", sel,
               {a_s, a_r3, a_r2, a_r1, a_shadow});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back(input bit use_b, input int spacing);
    int  last;
    int  n;
    bit  pend;
    bit  cur;
    logic rdy, sv;
    logic [2:0] rv;
    last = -1; n = 0; pend = 0; cur = 1;
    if (use_b) begin b_set = 1; b_sel = 2'd3; b_valid = 1; end
    else begin a_set = 1; a_sel = 2'd3; a_valid = 1; end
    for (int i = 0; i < 40; i++) begin
      rdy = use_b ? b_ready : a_ready;
      sv  = use_b ? b_s : a_s;
      rv  = use_b ? {b_r3, b_r2, b_r1} : {a_r3, a_r2, a_r1};
      checks++;
      if (sv & (|rv)) begin
        errors++;
        $display("FAIL b2b_overlap inst%0d cyc%0d s=%b res=%b", use_b, i, sv, rv);
      end
      if (pend) begin
        checks++;
        if ({sv, rv} !== (cur ? 4'b1000 : 4'b0111)) begin
          errors++;
          $display("FAIL b2b_lines inst%0d cyc%0d got %b want %b", use_b, i,
                   {sv, rv}, (cur ? 4'b1000 : 4'b0111));
        end
        cur = ~cur;
        if (use_b) b_set = cur; else a_set = cur;
        pend = 0;
      end
      if (rdy) begin
        if (last >= 0) begin
          checks++;
          if (i - last != spacing) begin
            errors++;
            $display("FAIL b2b_spacing inst%0d got %0d want %0d", use_b,
                     i - last, spacing);
          end
        end
        last = i; n++; pend = 1;
      end
      @(negedge clk);
    end
    if (use_b) b_valid = 0; else a_valid = 0;
    checks++;
    if (n != 39 / spacing + 1) begin
      errors++;
      $display("FAIL b2b_count inst%0d got %0d want %0d", use_b, n,
               39 / spacing + 1);
    end
    repeat (8) @(negedge clk);
    checks++;
    if ((use_b ? b_err : a_err) !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fb inst%0d got 1 want 0", use_b);
    end
  endtask

  task automatic test_mid_reset;
    b_set = 1; b_sel = 2'd0; b_valid = 1;
    @(negedge clk);
    b_valid = 0;
    repeat (4) @(negedge clk);
    checks++;
    if ({b_shadow, b_ready, b_busy} !== 3'b110) begin
      errors++;
      $display("FAIL mid_pre got %b want 110", {b_shadow, b_ready, b_busy});
    end
    b_valid = 1;
    @(negedge clk);
    b_valid = 0;
    checks++;
    if (b_s !== 1'b1) begin
      errors++;
      $display("FAIL mid_p1 got %b want 1", b_s);
    end
    @(negedge clk);
    checks++;
    if (b_s !== 1'b1) begin
      errors++;
      $display("FAIL mid_p2 got %b want 1", b_s);
    end
    b_n_res = 0;
    @(negedge clk);
    checks++;
    if ({b_s, b_r3, b_r2, b_r1, b_busy, b_ready, b_shadow} !== 7'b0000000) begin
      errors++;
      $display("FAIL mid_drop got %b want 0000000",
               {b_s, b_r3, b_r2, b_r1, b_busy, b_ready, b_shadow});
    end
    b_n_res = 1;
    @(negedge clk);
    checks++;
    if ({b_ready, b_busy} !== 2'b10) begin
      errors++;
      $display("FAIL mid_rel got %b want 10", {b_ready, b_busy});
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({b_s, b_r3, b_r2, b_r1, b_shadow} !== 5'b00000) begin
        errors++;
        $display("FAIL mid_quiet cyc%0d got %b want 00000", k,
                 {b_s, b_r3, b_r2, b_r1, b_shadow});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fb;
    a_force0 = 1;
    a_set = 1; a_sel = 2'd0; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL fb_early got %b want 0", a_err);
    end
    @(negedge clk);
    checks++;
    if (a_err !== FB_EN) begin
      errors++;
      $display("FAIL fb_set got %b want %b", a_err, FB_EN);
    end
    a_set = 0; a_sel = 2'd3; a_valid = 1;
    @(negedge clk);
    a_valid = 0;
    repeat (6) @(negedge clk);
    checks++;
    if ({a_err, a_shadow} !== {FB_EN, 1'b0}) begin
      errors++;
      $display("FAIL fb_sticky got %b want %b", {a_err, a_shadow}, {FB_EN, 1'b0});
    end
    a_force0 = 0;
    a_n_res = 0;
    @(negedge clk);
    a_n_res = 1;
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("FAIL fb_clear got %b want 0", a_err);
    end
    @(negedge clk);
  endtask

  initial begin
    a_valid = 0; a_set = 0; a_sel = 2'd0; a_force0 = 0;
    b_valid = 0; b_set = 0; b_sel = 2'd0;
    test_reset();
    test_set();
    test_set();
    test_reset_lines(2'd3, 3'b111);
    test_reset_lines(2'd1, 3'b010);
    test_reset_lines(2'd0, 3'b001);
    test_reset_lines(2'd2, 3'b100);
    test_back_to_back(1'b0, 4);
    test_mid_reset();
    test_back_to_back(1'b1, 5);
    test_fb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsff_pulse_driver.md
Name: rsff_pulse_driver

Overview:
- Clocked command-side driver for the asynchronous NOR-loop reset-set latch used throughout the design (one set input, three OR'ed reset inputs, q/nq outputs).
- Converts single-cycle set/reset commands into clean, mutually exclusive, width-controlled pulses on the latch's s/res1/res2/res3 inputs.
- Keeps a shadow copy of the latch state.
- Used wherever synchronous control logic must drive a latch without ever presenting set and reset simultaneously.

Parameters:
- PW, 2: pulse width in clk cycles, legal 1..15; 0 is treated as 1.
- GAP, 1: guard cycles after each pulse with all lines low, legal 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- n_res  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_set  input  1  1 = set command, 0 = reset command.
- cmd_sel  input  2  reset line select: 0 = res1, 1 = res2, 2 = res3, 3 = all three; ignored for set commands.
- cmd_ready  output  1  driver can accept a command this cycle.
- s  output  1  set pulse to latch.
- res1  output  1  reset pulse, line 1.
- res2  output  1  reset pulse, line 2.
- res3  output  1  reset pulse, line 3.
- busy  output  1  pulse or guard phase in progress.
- shadow_q  output  1  expected latch value.
- q_fb  input  1  latch q feedback; used only with the optional feature.
- fb_err  output  1  sticky feedback mismatch flag; tied 0 without the optional feature.

Behaviour:
- Reset: clock and reset are as decided: one clock; reset is synchronous and active-low (`clk`, `n_res`). While n_res=0 at a rising edge, the next state is:
  - FSM = IDLE
  - s = res1 = res2 = res3 = 0, busy = 0
  - cmd_ready = 0 during reset, 1 on the first cycle after release
  - shadow_q = 0, fb_err = 0, counter = 0
- Reset mid-pulse: all pulse lines drop at the same edge; the in-flight command is discarded.
- FSM states: IDLE, PULSE, GUARD.
- IDLE:
  - cmd_ready = 1.
  - Handshake: cmd_valid & cmd_ready at edge N latches cmd_set/cmd_sel, then goes to PULSE, counter = PW-1.
  - cmd_valid while not ready: ignored, not queued; the master must hold it.
- PULSE:
  - Selected lines high for exactly PW cycles (N+1..N+PW). busy = 1, cmd_ready = 0.
  - Set drives s only.
  - Reset drives the res line chosen by cmd_sel, or all three when cmd_sel=3.
  - At the final pulse cycle: shadow_q <= cmd_set.
  - Then GUARD if GAP>0, else IDLE.
- GUARD:
  - All lines low for GAP cycles, busy = 1, cmd_ready = 0, then IDLE.
- Back-to-back commands: minimum spacing is 1+PW+GAP cycles from accept to next accept.
- Redundant commands (set while shadow_q=1, or reset while shadow_q=0) still issue a full pulse.
- Invariant: s & (res1|res2|res3) is never 1 in any cycle, including across reset.
- All outputs are registered; there is no combinational path from cmd_* to s/res*.
- Counter: 4-bit down-counter; no wrap. Reaching 0 ends the phase.

Optional Feature:
- Macro: RSFF_PULSE_DRIVER_FBCHK_EN.
- Defined:
  - q_fb is sampled on the first cycle after the pulse ends (first GUARD cycle, or the IDLE cycle when GAP=0).
  - If q_fb != shadow_q, fb_err sets to 1 and stays set until n_res=0.
  - q_fb is sampled only at that point; it is ignored in all other cycles.
- Undefined:
  - q_fb is ignored and fb_err is constant 0.
  - Port list is identical in both builds.

Test Plan:
- Reset release: n_res=0 for 3 cycles, then 1 -> all pulse lines 0, shadow_q=0, busy=0, cmd_ready=1 on the first cycle after release.
- Set command (PW=2, GAP=1): cmd_valid=1, cmd_set=1 accepted at edge N -> s=1 exactly at N+1..N+2, 0 at N+3; cmd_ready=1 again at N+4; shadow_q=1.
- Reset all lines: cmd_set=0, cmd_sel=3 -> res1=res2=res3=1 for PW cycles, s=0 throughout, shadow_q=0. Repeat with cmd_sel=1 -> only res2 pulses.
- Back-to-back with cmd_valid held high alternating set/reset -> accepts spaced exactly 1+PW+GAP cycles; s and res never overlap; GAP=0 case spaced 1+PW cycles.
- Mid-pulse reset: n_res=0 on 2nd cycle of a PW=4 set pulse -> s=0 at the next edge, shadow_q=0, no further pulse after release.
- With RSFF_PULSE_DRIVER_FBCHK_EN, using a behavioural latch model on the outputs:
  - Correct loop -> fb_err stays 0.
  - q_fb forced 0 during a set command -> fb_err=1 after the pulse and stays 1 until n_res=0.
